// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART <-> ALU command sequencer.
package uart_alu_pkg;

  localparam int NB_DATA_DEF       = 8;
  localparam int NB_OP_DEF         = 6;
  localparam int TIMEOUT_TICKS_DEF = 640;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/byte_timeout_cnt.sv
// Inter-byte baud-tick counter; exists only when UART_ALU_CTRL_TIMEOUT_EN is defined.
`ifdef UART_ALU_CTRL_TIMEOUT_EN
module byte_timeout_cnt #(
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_TICKS);

  logic [CW-1:0] cnt;

  // Saturates at TERM; the sequencer leaves the enabled states on expiry.
  always_ff @(posedge clk) begin
    if (rst || clr || !en)               cnt <= '0;
    else if (tick && (cnt != TERM))      cnt <= cnt + 1'b1;
  end

  assign expired = en && !clr && (cnt == TERM);
endmodule
`endif

// File: rtl/uart_alu_ctrl.sv
// Collects A/B/opcode bytes from rx, drives the ALU, sends one result byte via tx.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OP         = NB_OP_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done_tick,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  state_e state, state_nx;
  logic   ld_a, ld_b, ld_op, ld_tx, drop_nx;
  logic   expired;
  logic   in_collect;

  assign in_collect = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tmo_nx, tmo_q;

  byte_timeout_cnt #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_tmo (
    .clk    (i_clk),
    .rst    (i_reset),
    .en     (in_collect),
    .clr    (i_rx_done_tick),
    .tick   (i_tick),
    .expired(expired)
  );

  assign tmo_nx    = expired;
  assign o_timeout = tmo_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) tmo_q <= 1'b0;
    else         tmo_q <= tmo_nx;
  end
`else
  logic unused_tick;
  assign unused_tick = i_tick ^ (TIMEOUT_TICKS == 0) ^ in_collect;
  assign expired     = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_WAIT_A;
    else         state <= state_nx;
  end

  // An accepted byte always beats a coincident timeout.
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT_A:  if (i_rx_done_tick) state_nx = ST_WAIT_B;
      ST_WAIT_B:  if (i_rx_done_tick) state_nx = ST_WAIT_OP;
                  else if (expired)   state_nx = ST_WAIT_A;
      ST_WAIT_OP: if (i_rx_done_tick) state_nx = ST_SEND;
                  else if (expired)   state_nx = ST_WAIT_A;
      ST_SEND:                        state_nx = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done_tick) state_nx = ST_WAIT_A;
      default:                        state_nx = ST_WAIT_A;
    endcase
  end

  always_comb begin
    ld_a    = (state == ST_WAIT_A)  && i_rx_done_tick;
    ld_b    = (state == ST_WAIT_B)  && i_rx_done_tick;
    ld_op   = (state == ST_WAIT_OP) && i_rx_done_tick;
    ld_tx   = (state == ST_SEND);
    drop_nx = is_busy(state) && i_rx_done_tick;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      if (ld_a)  o_alu_a   <= i_rx_data;
      if (ld_b)  o_alu_b   <= i_rx_data;
      if (ld_op) o_alu_op  <= i_rx_data[NB_OP-1:0];
      if (ld_tx) o_tx_data <= i_alu_result;
      o_tx_start <= ld_tx;
      o_busy     <= is_busy(state_nx);
      o_drop     <= drop_nx;
    end
  end

endmodule
